// File: rtl/memory_game_pkg.sv
// Shared constants for the memory-game switch front end: switch count,
// release-ID width and the game-reset chord indices.
package memory_game_pkg;

  localparam int unsigned NUM_SW  = 4;
  localparam int unsigned ID_W    = 2;
  localparam int unsigned CHORD_A = 0;
  localparam int unsigned CHORD_B = 1;

  typedef logic [NUM_SW-1:0] sw_vec_t;

  localparam sw_vec_t CHORD_MASK = (sw_vec_t'(1) << CHORD_A) | (sw_vec_t'(1) << CHORD_B);

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [ID_W-1:0] lowest_set(input sw_vec_t v);
    logic [ID_W-1:0] idx;
    idx = '0;
    for (int unsigned i = NUM_SW; i > 0; i--) begin
      if (v[i-1]) idx = ID_W'(i - 1);
    end
    return idx;
  endfunction

endpackage

// File: rtl/debounce_filter.sv
// One switch channel: 2-flop synchroniser followed by a stability counter
// that accepts a level change after DEBOUNCE_LIMIT consecutive differing clocks.
module debounce_filter #(
  parameter int unsigned DEBOUNCE_LIMIT = 250000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_level
);

  localparam int unsigned CNT_W = (DEBOUNCE_LIMIT > 1) ? $clog2(DEBOUNCE_LIMIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_LIMIT - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_MAX) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= i_raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_level = level_q;

endmodule

// File: rtl/debounce_event_encoder.sv
// Debounces four push buttons and encodes debounced releases as one-cycle
// ID events; the 0+1 chord suppresses events. LONG_PRESS_EN adds hold flags.
module debounce_event_encoder
  import memory_game_pkg::*;
#(
  parameter int unsigned DEBOUNCE_LIMIT   = 250000,
  parameter int unsigned LONG_PRESS_LIMIT = 25000000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [3:0] i_switch,
  output logic [3:0] o_switch,
  output logic       o_release_dv,
  output logic [1:0] o_release_id,
  output logic       o_combo
`ifdef LONG_PRESS_EN
  ,
  output logic [3:0] o_long_press
`endif
);

  sw_vec_t         level;
  sw_vec_t         prev_q;
  sw_vec_t         pend_q, pend_d;
  sw_vec_t         mask_q, mask_d;
  sw_vec_t         fall, avail;
  logic            dv_q, dv_d;
  logic [ID_W-1:0] id_q, id_d;

  for (genvar g = 0; g < NUM_SW; g++) begin : g_ch
    debounce_filter #(.DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)) u_filter (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_raw   (i_switch[g]),
      .o_level (level[g])
    );
  end

  assign o_switch = level;
  assign o_combo  = level[CHORD_A] & level[CHORD_B];
  assign fall     = prev_q & ~level;

  // mask_q remembers that the chord was held, so the falls ending it are swallowed.
  always_comb begin
    dv_d   = 1'b0;
    id_d   = '0;
    avail  = '0;
    pend_d = pend_q;
    mask_d = mask_q & ~fall;
    if (o_combo) begin
      mask_d = CHORD_MASK;
      pend_d = '0;
    end else begin
      avail = pend_q | (fall & ~mask_q);
      if (avail != '0) begin
        dv_d = 1'b1;
        id_d = lowest_set(avail);
      end
      pend_d = avail & ~(sw_vec_t'(dv_d) << id_d);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      prev_q <= '0;
      pend_q <= '0;
      mask_q <= '0;
      dv_q   <= 1'b0;
      id_q   <= '0;
    end else begin
      prev_q <= level;
      pend_q <= pend_d;
      mask_q <= mask_d;
      dv_q   <= dv_d;
      id_q   <= id_d;
    end
  end

  assign o_release_dv = dv_q;
  assign o_release_id = id_q;

`ifdef LONG_PRESS_EN
  localparam int unsigned LP_W = (LONG_PRESS_LIMIT > 1) ? $clog2(LONG_PRESS_LIMIT) : 1;
  localparam logic [LP_W-1:0] LP_MAX = LP_W'(LONG_PRESS_LIMIT - 1);

  logic [LP_W-1:0] hold_q [NUM_SW];
  logic [LP_W-1:0] hold_d [NUM_SW];

  always_comb begin
    for (int unsigned i = 0; i < NUM_SW; i++) begin
      hold_d[i] = '0;
      if (level[i]) hold_d[i] = (hold_q[i] == LP_MAX) ? hold_q[i] : hold_q[i] + 1'b1;
      o_long_press[i] = (hold_q[i] == LP_MAX);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < NUM_SW; i++) hold_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_SW; i++) hold_q[i] <= hold_d[i];
    end
  end
`else
  localparam int unsigned LP_LIMIT_UNUSED = LONG_PRESS_LIMIT;
`endif

endmodule

// File: tb/tb_debounce_event_encoder.sv
// Directed bench for debounce_event_encoder with DEBOUNCE_LIMIT=16 and
// LONG_PRESS_LIMIT=64; long-press steps only when LONG_PRESS_EN is defined.
module tb_debounce_event_encoder;

  logic       clk;
  logic       rst_n;
  logic [3:0] sw_in;
  logic [3:0] sw_out;
  logic       rel_dv;
  logic [1:0] rel_id;
  logic       combo;
`ifdef LONG_PRESS_EN
  logic [3:0] long_press;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  debounce_event_encoder #(
    .DEBOUNCE_LIMIT   (16),
    .LONG_PRESS_LIMIT (64)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_switch     (sw_in),
    .o_switch     (sw_out),
    .o_release_dv (rel_dv),
    .o_release_id (rel_id),
    .o_combo      (combo)
`ifdef LONG_PRESS_EN
    ,
    .o_long_press (long_press)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    sw_in = 4'b0000;
    tick(3);
    chk("reset_sw", {4'b0, sw_out}, 8'h00);
    chk("reset_dv", {7'b0, rel_dv}, 8'h00);
    chk("reset_id", {6'b0, rel_id}, 8'h00);
    chk("reset_combo", {7'b0, combo}, 8'h00);
    rst_n = 1'b1;
    tick(2);

    // Glitch: 10-cycle pulse on switch 2 must be ignored.
    sw_in = 4'b0100;
    tick(10);
    sw_in = 4'b0000;
    for (int i = 0; i < 30; i++) begin
      chk("glitch_sw", {4'b0, sw_out}, 8'h00);
      chk("glitch_dv", {7'b0, rel_dv}, 8'h00);
      tick(1);
    end

    // Clean press/release on switch 1.
    sw_in = 4'b0010;
    tick(17);
    chk("press1_early", {4'b0, sw_out}, 8'h00);
    tick(1);
    chk("press1_rise", {4'b0, sw_out}, 8'h02);
    chk("press1_combo", {7'b0, combo}, 8'h00);
    tick(22);
    chk("press1_hold_dv", {7'b0, rel_dv}, 8'h00);
    sw_in = 4'b0000;
    tick(17);
    chk("rel1_early", {4'b0, sw_out}, 8'h02);
    tick(1);
    chk("rel1_fall", {4'b0, sw_out}, 8'h00);
    chk("rel1_dv_not_yet", {7'b0, rel_dv}, 8'h00);
    tick(1);
    chk("rel1_dv", {7'b0, rel_dv}, 8'h01);
    chk("rel1_id", {6'b0, rel_id}, 8'h01);
    tick(1);
    chk("rel1_dv_end", {7'b0, rel_dv}, 8'h00);
    chk("rel1_id_idle", {6'b0, rel_id}, 8'h00);

    // Simultaneous release of switches 3 and 2.
    sw_in = 4'b1100;
    tick(18);
    chk("press32", {4'b0, sw_out}, 8'h0C);
    tick(5);
    sw_in = 4'b0000;
    tick(18);
    chk("rel32_fall", {4'b0, sw_out}, 8'h00);
    chk("rel32_dv0", {7'b0, rel_dv}, 8'h00);
    tick(1);
    chk("rel32_dv1", {7'b0, rel_dv}, 8'h01);
    chk("rel32_id1", {6'b0, rel_id}, 8'h02);
    tick(1);
    chk("rel32_dv2", {7'b0, rel_dv}, 8'h01);
    chk("rel32_id2", {6'b0, rel_id}, 8'h03);
    tick(1);
    chk("rel32_dv3", {7'b0, rel_dv}, 8'h00);

    // Chord 0+1: combo high while held, no release events at all.
    sw_in = 4'b0011;
    tick(18);
    chk("chord_sw", {4'b0, sw_out}, 8'h03);
    chk("chord_combo", {7'b0, combo}, 8'h01);
    for (int i = 0; i < 10; i++) begin
      chk("chord_hold_dv", {7'b0, rel_dv}, 8'h00);
      tick(1);
    end
    sw_in = 4'b0000;
    tick(18);
    chk("chord_rel_sw", {4'b0, sw_out}, 8'h00);
    chk("chord_rel_combo", {7'b0, combo}, 8'h00);
    for (int i = 0; i < 6; i++) begin
      chk("chord_rel_dv", {7'b0, rel_dv}, 8'h00);
      tick(1);
    end

    // Mid-count reset: switch 0 debounced, switch 3 counting when reset hits.
    sw_in = 4'b0001;
    tick(18);
    chk("pre_rst_sw", {4'b0, sw_out}, 8'h01);
    sw_in = 4'b1001;
    tick(8);
    rst_n = 1'b0;
    #1;
    chk("rst_async_sw", {4'b0, sw_out}, 8'h00);
    chk("rst_async_dv", {7'b0, rel_dv}, 8'h00);
    tick(3);
    rst_n = 1'b1;
    tick(17);
    chk("post_rst_early", {4'b0, sw_out}, 8'h00);
    tick(1);
    chk("post_rst_rise", {4'b0, sw_out}, 8'h09);
    sw_in = 4'b0000;
    tick(18);
    chk("post_rst_fall", {4'b0, sw_out}, 8'h00);
    tick(1);
    chk("post_rst_id_a", {5'b0, rel_dv, rel_id}, 8'h04);
    tick(1);
    chk("post_rst_id_b", {5'b0, rel_dv, rel_id}, 8'h07);
    tick(1);
    chk("post_rst_idle", {5'b0, rel_dv, rel_id}, 8'h00);

`ifdef LONG_PRESS_EN
    // Long press on switch 0: flag from hold cycle 64, clears after release.
    sw_in = 4'b0001;
    tick(18);
    chk("lp_rise", {4'b0, sw_out}, 8'h01);
    chk("lp_flag0", {4'b0, long_press}, 8'h00);
    tick(62);
    chk("lp_flag_early", {4'b0, long_press}, 8'h00);
    tick(1);
    chk("lp_flag_set", {4'b0, long_press}, 8'h01);
    tick(37);
    chk("lp_flag_hold", {4'b0, long_press}, 8'h01);
    sw_in = 4'b0000;
    tick(18);
    chk("lp_fall", {4'b0, sw_out}, 8'h00);
    chk("lp_flag_fall", {4'b0, long_press}, 8'h01);
    tick(1);
    chk("lp_evt", {5'b0, rel_dv, rel_id}, 8'h04);
    chk("lp_flag_clr", {4'b0, long_press}, 8'h00);
`endif

    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
